// File: rtl/dwconv2d_stream_engine.sv
// Depthwise 2-D convolution engine (N=1, NHWC, signed int8), one filter tap per cycle.
// Optional fused ReLU on the written accumulator when DWCONV_RELU_EN is defined.
module dwconv2d_stream_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int MAX_K  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_in_h,
    input  logic [DIM_W-1:0]  cfg_in_w,
    input  logic [DIM_W-1:0]  cfg_ch,
    input  logic [DIM_W-1:0]  cfg_kh,
    input  logic [DIM_W-1:0]  cfg_kw,
    input  logic [DIM_W-1:0]  cfg_stride_h,
    input  logic [DIM_W-1:0]  cfg_stride_w,
    input  logic [DIM_W-1:0]  cfg_pad_t,
    input  logic [DIM_W-1:0]  cfg_pad_l,
    input  logic [DIM_W-1:0]  cfg_out_h,
    input  logic [DIM_W-1:0]  cfg_out_w,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rd_data,
    output logic [ADDR_W-1:0] flt_rd_addr,
    input  logic [DATA_W-1:0] flt_rd_data,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [ACC_W-1:0]  out_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DW2   = 2 * DIM_W;
    localparam int PW    = 2 * DIM_W + 2;
    localparam int PRD_W = 2 * DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

    typedef struct packed {
        logic [DIM_W-1:0] in_h;
        logic [DIM_W-1:0] in_w;
        logic [DIM_W-1:0] ch;
        logic [DIM_W-1:0] kh;
        logic [DIM_W-1:0] kw;
        logic [DIM_W-1:0] stride_h;
        logic [DIM_W-1:0] stride_w;
        logic [DIM_W-1:0] pad_t;
        logic [DIM_W-1:0] pad_l;
        logic [DIM_W-1:0] out_h;
        logic [DIM_W-1:0] out_w;
    } cfg_t;

    state_t                  state_q, state_d;
    cfg_t                    cfg_q, cfg_d, cfg_in;
    logic                    err_q, err_d;
    logic                    pend_q, pend_d;
    logic [DIM_W-1:0]        oy_q, oy_d, ox_q, ox_d, c_q, c_d, ky_q, ky_d, kx_q, kx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic                    cfg_bad;
    logic [DW2-1:0]          oy_base, ox_base;
    logic signed [PW-1:0]    iy, ix;
    logic                    tap_in;
    logic                    last_kx, last_ky, last_c, last_ox, last_oy;
    logic [ADDR_W-1:0]       in_addr, flt_addr, out_addr;
    logic signed [PRD_W-1:0] prod;
    logic [ACC_W-1:0]        wr_value;

    assign cfg_in = '{in_h: cfg_in_h, in_w: cfg_in_w, ch: cfg_ch, kh: cfg_kh, kw: cfg_kw,
                      stride_h: cfg_stride_h, stride_w: cfg_stride_w, pad_t: cfg_pad_t,
                      pad_l: cfg_pad_l, out_h: cfg_out_h, out_w: cfg_out_w};

    assign cfg_bad = (cfg_kh == '0) || (cfg_kw == '0) || (cfg_ch == '0) ||
                     (cfg_stride_h == '0) || (cfg_stride_w == '0) ||
                     (cfg_out_h == '0) || (cfg_out_w == '0) ||
                     (cfg_kh > DIM_W'(MAX_K)) || (cfg_kw > DIM_W'(MAX_K));

    // Input coordinates are formed wide and signed so padding yields negatives.
    assign oy_base = DW2'(oy_q) * DW2'(cfg_q.stride_h);
    assign ox_base = DW2'(ox_q) * DW2'(cfg_q.stride_w);
    assign iy      = $signed(PW'(oy_base) + PW'(ky_q)) - $signed(PW'(cfg_q.pad_t));
    assign ix      = $signed(PW'(ox_base) + PW'(kx_q)) - $signed(PW'(cfg_q.pad_l));
    assign tap_in  = !iy[PW-1] && !ix[PW-1] &&
                     (iy < $signed(PW'(cfg_q.in_h))) && (ix < $signed(PW'(cfg_q.in_w)));

    assign last_kx = (kx_q == cfg_q.kw - DIM_W'(1));
    assign last_ky = (ky_q == cfg_q.kh - DIM_W'(1));
    assign last_c  = (c_q  == cfg_q.ch - DIM_W'(1));
    assign last_ox = (ox_q == cfg_q.out_w - DIM_W'(1));
    assign last_oy = (oy_q == cfg_q.out_h - DIM_W'(1));

    assign in_addr  = (ADDR_W'($unsigned(iy)) * ADDR_W'(cfg_q.in_w) + ADDR_W'($unsigned(ix)))
                      * ADDR_W'(cfg_q.ch) + ADDR_W'(c_q);
    assign flt_addr = (ADDR_W'(ky_q) * ADDR_W'(cfg_q.kw) + ADDR_W'(kx_q))
                      * ADDR_W'(cfg_q.ch) + ADDR_W'(c_q);
    assign out_addr = (ADDR_W'(oy_q) * ADDR_W'(cfg_q.out_w) + ADDR_W'(ox_q))
                      * ADDR_W'(cfg_q.ch) + ADDR_W'(c_q);

    assign prod = PRD_W'($signed(in_rd_data)) * PRD_W'($signed(flt_rd_data));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d = state_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        c_d     = c_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        pend_d  = 1'b0;
        acc_d   = pend_q ? acc_q + ACC_W'(prod) : acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d   = cfg_in;
                    err_d   = cfg_bad;
                    oy_d    = '0;
                    ox_d    = '0;
                    c_d     = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    state_d = cfg_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                pend_d = tap_in;
                if (ky_q == '0 && kx_q == '0) begin
                    acc_d = '0;
                end
                if (last_kx) begin
                    kx_d = '0;
                    if (last_ky) begin
                        ky_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        ky_d = ky_q + DIM_W'(1);
                    end
                end else begin
                    kx_d = kx_q + DIM_W'(1);
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                // Element indices advance only here, after they have addressed the write.
                state_d = S_RUN;
                if (last_c) begin
                    c_d = '0;
                    if (last_ox) begin
                        ox_d = '0;
                        if (last_oy) begin
                            state_d = S_DONE;
                        end else begin
                            oy_d = oy_q + DIM_W'(1);
                        end
                    end else begin
                        ox_d = ox_q + DIM_W'(1);
                    end
                end else begin
                    c_d = c_q + DIM_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            oy_q    <= '0;
            ox_q    <= '0;
            c_q     <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            c_q     <= c_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            acc_q   <= acc_d;
        end
    end

`ifdef DWCONV_RELU_EN
    assign wr_value = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign wr_value = acc_q;
`endif

    assign in_rd_en    = (state_q == S_RUN) && tap_in;
    assign in_rd_addr  = in_rd_en ? in_addr : '0;
    assign flt_rd_addr = in_rd_en ? flt_addr : '0;
    assign out_wr_en   = (state_q == S_WRITE);
    assign out_wr_addr = out_wr_en ? out_addr : '0;
    assign out_wr_data = out_wr_en ? wr_value : '0;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

endmodule
